dma_ctrl: RTL and testbench

//  Cycle-stealing DMA engine on the shared 16-bit data/IO/video bus. Copies LEN bytes SRC->DST
//  (e.g. d_ram -> v_mem) using only bus cycles the CPU leaves idle. The CPU always has priority
//  and is never stalled. Programmed through 8 byte registers in the I/O window.

---
 rtl/dma_ctrl_pkg.sv | 35 +++
 rtl/dma_ctrl_regs.sv | 117 +++++++++++
 rtl/dma_ctrl.sv | 162 ++++++++++++++++
 tb/tb_dma_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_ctrl_pkg.sv
// dma_ctrl_pkg: shared constants for the cycle-stealing DMA engine.
//   - sequencer state encoding (S_IDLE, S_RD, S_CAP, S_WR)
//   - register indices inside the 8-byte I/O window and its base address
//   - CTRL / STATUS bit positions and the STATUS byte packer
// Optional feature macro used by the importing files: DMA_FILL_EN.
package dma_ctrl_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_CAP  = 2'd2;
    localparam logic [1:0] S_WR   = 2'd3;

    localparam logic [2:0] REG_SRC_LO = 3'd0;
    localparam logic [2:0] REG_SRC_HI = 3'd1;
    localparam logic [2:0] REG_DST_LO = 3'd2;
    localparam logic [2:0] REG_DST_HI = 3'd3;
    localparam logic [2:0] REG_LEN_LO = 3'd4;
    localparam logic [2:0] REG_LEN_HI = 3'd5;
    localparam logic [2:0] REG_CTRL   = 3'd6;
    localparam logic [2:0] REG_STATUS = 3'd7;

    localparam int unsigned CTRL_START = 0;
    localparam int unsigned CTRL_FILL  = 1;
    localparam int unsigned CTRL_ABORT = 7;

    localparam int unsigned ST_BUSY = 0;
    localparam int unsigned ST_DONE = 1;

    localparam logic [15:0] DMA_IO_BASE = 16'h1010;

    function automatic logic [7:0] status_byte(input logic busy, input logic done);
        return {6'b0, done, busy};
    endfunction

endpackage

// File: rtl/dma_ctrl_regs.sv
// dma_regs: programming interface of the DMA engine.
//   Decodes byte writes into merged counter load values, produces START /
//   ABORT / done-clear pulses, holds the FILL mode bit and registers read data.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   reg_addr_i/reg_din_i    register index and write data
//   reg_w_en_i/reg_r_en_i   write / read strobes
//   reg_dout_o              read data, valid the cycle after reg_r_en_i
//   busy_i, done_i          live engine status
//   src_i/dst_i/len_i       live counters (read back and merged on load)
//   *_we_o / *_load_o       counter load strobe and merged load value
//   start_o, abort_o        command pulses
//   clr_done_o              STATUS write clears done
//   fill_o                  fill mode (only with DMA_FILL_EN, else 0)
module dma_regs
    import dma_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned LEN_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [2:0]        reg_addr_i,
    input  logic [7:0]        reg_din_i,
    input  logic              reg_w_en_i,
    input  logic              reg_r_en_i,
    output logic [7:0]        reg_dout_o,
    input  logic              busy_i,
    input  logic              done_i,
    input  logic [ADDR_W-1:0] src_i,
    input  logic [ADDR_W-1:0] dst_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              src_we_o,
    output logic [ADDR_W-1:0] src_load_o,
    output logic              dst_we_o,
    output logic [ADDR_W-1:0] dst_load_o,
    output logic              len_we_o,
    output logic [LEN_W-1:0]  len_load_o,
    output logic              start_o,
    output logic              abort_o,
    output logic              clr_done_o,
    output logic              fill_o
);

    logic       wr_ok;
    logic       ctrl_wr;
    logic [7:0] rd_mux;
    logic [7:0] dout_q;

    // Configuration writes are locked out while a transfer runs.
    assign wr_ok   = reg_w_en_i & ~busy_i;
    assign ctrl_wr = reg_w_en_i & (reg_addr_i == REG_CTRL);

    assign src_we_o = wr_ok & ((reg_addr_i == REG_SRC_LO) | (reg_addr_i == REG_SRC_HI));
    assign dst_we_o = wr_ok & ((reg_addr_i == REG_DST_LO) | (reg_addr_i == REG_DST_HI));
    assign len_we_o = wr_ok & ((reg_addr_i == REG_LEN_LO) | (reg_addr_i == REG_LEN_HI));

    // Byte merge: only the addressed half of each counter is replaced.
    always_comb begin
        src_load_o = src_i;
        dst_load_o = dst_i;
        len_load_o = len_i;
        if (reg_addr_i[0]) begin
            src_load_o[15:8] = reg_din_i;
            dst_load_o[15:8] = reg_din_i;
            len_load_o[15:8] = reg_din_i;
        end else begin
            src_load_o[7:0] = reg_din_i;
            dst_load_o[7:0] = reg_din_i;
            len_load_o[7:0] = reg_din_i;
        end
    end

    // ABORT dominates START in the same write.
    assign start_o    = wr_ok & ctrl_wr & reg_din_i[CTRL_START] & ~reg_din_i[CTRL_ABORT];
    assign abort_o    = ctrl_wr & busy_i & reg_din_i[CTRL_ABORT];
    assign clr_done_o = reg_w_en_i & (reg_addr_i == REG_STATUS);

`ifdef DMA_FILL_EN
    logic fill_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fill_q <= 1'b0;
        end else if (wr_ok && ctrl_wr) begin
            fill_q <= reg_din_i[CTRL_FILL];
        end
    end
    assign fill_o = fill_q;
`else
    assign fill_o = 1'b0;
`endif

    always_comb begin
        rd_mux = '0;
        case (reg_addr_i)
            REG_SRC_LO: rd_mux = src_i[7:0];
            REG_SRC_HI: rd_mux = src_i[15:8];
            REG_DST_LO: rd_mux = dst_i[7:0];
            REG_DST_HI: rd_mux = dst_i[15:8];
            REG_LEN_LO: rd_mux = len_i[7:0];
            REG_LEN_HI: rd_mux = len_i[15:8];
            REG_CTRL:   rd_mux = {6'b0, fill_o, 1'b0};
            default:    rd_mux = status_byte(busy_i, done_i);
        endcase
    end

    // Sampling the pre-write state gives read-before-write on a same-cycle access.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dout_q <= '0;
        end else if (reg_r_en_i) begin
            dout_q <= rd_mux;
        end
    end
    assign reg_dout_o = dout_q;

endmodule

// File: rtl/dma_ctrl.sv
// dma_ctrl: cycle-stealing DMA engine on the shared 16-bit bus. Copies LEN
// bytes from SRC to DST using only cycles where cpu_req is low; the CPU is
// never stalled. Sequencer: IDLE -> RD -> CAP -> WR -> (RD | IDLE).
// Optional macro DMA_FILL_EN: fill mode writes SRC_LO to every DST byte.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   reg_addr/reg_din         register index / write data (8-byte I/O window)
//   reg_w_en/reg_r_en        register strobes; reg_dout valid one cycle later
//   cpu_req                  CPU uses the bus this cycle (always wins)
//   dma_grant                DMA owns the bus this cycle
//   bus_addr/bus_wdata       DMA address / write data (0 when not granted)
//   bus_w_en/bus_r_en        DMA strobes (only while granted)
//   bus_rdata                memory read data, one cycle after bus_r_en
module dma_ctrl
    import dma_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        reg_addr,
    input  logic [7:0]        reg_din,
    input  logic              reg_w_en,
    input  logic              reg_r_en,
    output logic [7:0]        reg_dout,
    input  logic              cpu_req,
    output logic              dma_grant,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [7:0]        bus_wdata,
    output logic              bus_w_en,
    output logic              bus_r_en,
    input  logic [7:0]        bus_rdata
);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [7:0]        data_q, data_d;
    logic              done_q, done_d;

    logic              busy;
    logic              src_we, dst_we, len_we;
    logic [ADDR_W-1:0] src_load, dst_load;
    logic [LEN_W-1:0]  len_load;
    logic              start, abort, clr_done, fill;
    logic              rd_gnt, wr_gnt;

    assign busy = (state_q != S_IDLE);

    dma_regs #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_regs (
        .clk_i      (clk),
        .rst_i      (rst),
        .reg_addr_i (reg_addr),
        .reg_din_i  (reg_din),
        .reg_w_en_i (reg_w_en),
        .reg_r_en_i (reg_r_en),
        .reg_dout_o (reg_dout),
        .busy_i     (busy),
        .done_i     (done_q),
        .src_i      (src_q),
        .dst_i      (dst_q),
        .len_i      (len_q),
        .src_we_o   (src_we),
        .src_load_o (src_load),
        .dst_we_o   (dst_we),
        .dst_load_o (dst_load),
        .len_we_o   (len_we),
        .len_load_o (len_load),
        .start_o    (start),
        .abort_o    (abort),
        .clr_done_o (clr_done),
        .fill_o     (fill)
    );

    // Grant is purely combinational; rst gating keeps strobes off during reset.
    assign rd_gnt    = ~rst & (state_q == S_RD) & ~cpu_req;
    assign wr_gnt    = ~rst & (state_q == S_WR) & ~cpu_req;
    assign dma_grant = rd_gnt | wr_gnt;
    assign bus_r_en  = rd_gnt;
    assign bus_w_en  = wr_gnt;
    assign bus_addr  = rd_gnt ? src_q : (wr_gnt ? dst_q : '0);
    assign bus_wdata = wr_gnt ? (fill ? src_q[7:0] : data_q) : '0;

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        data_d  = data_q;
        done_d  = done_q;

        if (clr_done) done_d = 1'b0;
        if (src_we)   src_d  = src_load;
        if (dst_we)   dst_d  = dst_load;
        if (len_we)   len_d  = len_load;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len_q == '0) begin
                        done_d = 1'b1;
                    end else begin
                        done_d  = 1'b0;
                        state_d = fill ? S_WR : S_RD;
                    end
                end
            end
            S_RD: begin
                if (!cpu_req) state_d = S_CAP;
            end
            S_CAP: begin
                data_d  = bus_rdata;
                state_d = S_WR;
            end
            default: begin // S_WR
                if (!cpu_req) begin
                    if (!fill) src_d = src_q + ADDR_W'(1);
                    dst_d = dst_q + ADDR_W'(1);
                    len_d = len_q - LEN_W'(1);
                    if (len_q == LEN_W'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = fill ? S_WR : S_RD;
                    end
                end
            end
        endcase

        // Abort overrides everything, including a write granted this cycle.
        if (abort) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            src_d   = src_q;
            dst_d   = dst_q;
            len_d   = len_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_dma_ctrl.sv
module tb_dma_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  reg_addr = '0;
    logic [7:0]  reg_din = '0;
    logic        reg_w_en = 1'b0;
    logic        reg_r_en = 1'b0;
    logic [7:0]  reg_dout;
    logic        cpu_req = 1'b0;
    logic        dma_grant;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_w_en;
    logic        bus_r_en;
    logic [7:0]  bus_rdata;

    dma_ctrl #(.ADDR_W(16), .LEN_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .reg_addr  (reg_addr),
        .reg_din   (reg_din),
        .reg_w_en  (reg_w_en),
        .reg_r_en  (reg_r_en),
        .reg_dout  (reg_dout),
        .cpu_req   (cpu_req),
        .dma_grant (dma_grant),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_w_en  (bus_w_en),
        .bus_r_en  (bus_r_en),
        .bus_rdata (bus_rdata)
    );

    always #5 clk = ~clk;

    // Memory model with a backdoor poke port; read data returned one cycle later.
    logic [7:0]  mem [0:65535];
    logic [7:0]  rdata_q = '0;
    logic        pk_we = 1'b0;
    logic [15:0] pk_addr = '0;
    logic [7:0]  pk_data = '0;
    int unsigned rd_cnt = 0, wr_cnt = 0, viol = 0;
    logic [15:0] rd_log [0:15];

    assign bus_rdata = rdata_q;

    always @(posedge clk) begin
        if (pk_we) mem[pk_addr] <= pk_data;
        if (bus_r_en) begin
            rdata_q <= mem[bus_addr];
            rd_log[rd_cnt % 16] <= bus_addr;
            rd_cnt <= rd_cnt + 1;
        end
        if (bus_w_en) begin
            mem[bus_addr] <= bus_wdata;
            wr_cnt <= wr_cnt + 1;
        end
        if (dma_grant && cpu_req) viol <= viol + 1;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        reg_addr = a; reg_din = d; reg_w_en = 1'b1;
        @(negedge clk);
        reg_w_en = 1'b0;
    endtask

    task automatic rd_reg(input logic [2:0] a, output logic [7:0] d);
        @(negedge clk);
        reg_addr = a; reg_r_en = 1'b1;
        @(negedge clk);
        reg_r_en = 1'b0;
        d = reg_dout;
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        pk_addr = a; pk_data = d; pk_we = 1'b1;
        @(negedge clk);
        pk_we = 1'b0;
    endtask

    task automatic setup(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n);
        wr_reg(3'd0, s[7:0]); wr_reg(3'd1, s[15:8]);
        wr_reg(3'd2, d[7:0]); wr_reg(3'd3, d[15:8]);
        wr_reg(3'd4, n[7:0]); wr_reg(3'd5, n[15:8]);
    endtask

    // Waits for the write counter to reach target; cyc = negedges elapsed.
    task automatic wait_writes(input int unsigned target, input int budget, input bit tog,
                               input string name, output int cyc);
        cyc = 0;
        while (wr_cnt < target && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (tog) cpu_req = ~cpu_req;
        end
        cpu_req = 1'b0;
        if (wr_cnt < target) check({name, "_timeout"}, wr_cnt, target);
    endtask

    typedef struct {
        logic [2:0] a;
        logic [7:0] d;
        bit         we;
        bit         re;
        logic [7:0] exp;
    } vec_t;

`ifdef DMA_FILL_EN
    localparam logic [7:0] FILL_RB = 8'h02;
`else
    localparam logic [7:0] FILL_RB = 8'h00;
`endif

    initial begin
        vec_t        vecs [19];
        logic [7:0]  rv;
        int          cyc;
        int unsigned r0, w0;

        vecs[0]  = '{3'd0, 8'h00, 1'b0, 1'b1, 8'h00};
        vecs[1]  = '{3'd7, 8'h00, 1'b0, 1'b1, 8'h00};
        vecs[2]  = '{3'd5, 8'h00, 1'b0, 1'b1, 8'h00};
        vecs[3]  = '{3'd0, 8'h12, 1'b1, 1'b1, 8'h00};
        vecs[4]  = '{3'd0, 8'h00, 1'b0, 1'b1, 8'h12};
        vecs[5]  = '{3'd1, 8'h34, 1'b1, 1'b0, 8'h00};
        vecs[6]  = '{3'd1, 8'h00, 1'b0, 1'b1, 8'h34};
        vecs[7]  = '{3'd2, 8'h56, 1'b1, 1'b1, 8'h00};
        vecs[8]  = '{3'd3, 8'h78, 1'b1, 1'b1, 8'h00};
        vecs[9]  = '{3'd3, 8'h00, 1'b0, 1'b1, 8'h78};
        vecs[10] = '{3'd4, 8'h9A, 1'b1, 1'b1, 8'h00};
        vecs[11] = '{3'd5, 8'hBC, 1'b1, 1'b0, 8'h00};
        vecs[12] = '{3'd4, 8'h00, 1'b0, 1'b1, 8'h9A};
        vecs[13] = '{3'd5, 8'h00, 1'b0, 1'b1, 8'hBC};
        vecs[14] = '{3'd6, 8'h02, 1'b1, 1'b1, 8'h00};
        vecs[15] = '{3'd6, 8'h00, 1'b0, 1'b1, FILL_RB};
        vecs[16] = '{3'd6, 8'h00, 1'b1, 1'b1, FILL_RB};
        vecs[17] = '{3'd6, 8'h00, 1'b0, 1'b1, 8'h00};
        vecs[18] = '{3'd7, 8'hFF, 1'b1, 1'b1, 8'h00};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_grant", dma_grant, 0);
        check("rst_wen",   bus_w_en, 0);
        check("rst_ren",   bus_r_en, 0);
        check("rst_dout",  reg_dout, 0);
        rst = 1'b0;

        // Register table: same-cycle read returns the pre-write value
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            reg_addr = vecs[i].a; reg_din = vecs[i].d;
            reg_w_en = vecs[i].we; reg_r_en = vecs[i].re;
            @(negedge clk);
            reg_w_en = 1'b0; reg_r_en = 1'b0;
            if (vecs[i].re) check($sformatf("vec%0d", i), reg_dout, vecs[i].exp);
        end

        // 1: uncontended copy of 4 bytes
        poke(16'h0100, 8'h11); poke(16'h0101, 8'h22);
        poke(16'h0102, 8'h33); poke(16'h0103, 8'h44);
        setup(16'h0100, 16'h2000, 16'd4);
        r0 = rd_cnt; w0 = wr_cnt;
        wr_reg(3'd6, 8'h01);
        wait_writes(w0 + 4, 100, 1'b0, "t1", cyc);
        check("t1_cycles", cyc, 12);
        check("t1_reads", rd_cnt - r0, 4);
        check("t1_m0", mem[16'h2000], 8'h11);
        check("t1_m1", mem[16'h2001], 8'h22);
        check("t1_m2", mem[16'h2002], 8'h33);
        check("t1_m3", mem[16'h2003], 8'h44);
        rd_reg(3'd7, rv); check("t1_status", rv, 8'h02);
        rd_reg(3'd4, rv); check("t1_len_lo", rv, 8'h00);
        rd_reg(3'd5, rv); check("t1_len_hi", rv, 8'h00);
        rd_reg(3'd0, rv); check("t1_src_lo", rv, 8'h04);
        rd_reg(3'd3, rv); check("t1_dst_hi", rv, 8'h20);

        // 2: CPU contention on alternating cycles
        poke(16'h0200, 8'hA1); poke(16'h0201, 8'hB2);
        poke(16'h0202, 8'hC3); poke(16'h0203, 8'hD4);
        setup(16'h0200, 16'h2100, 16'd4);
        r0 = rd_cnt; w0 = wr_cnt;
        wr_reg(3'd6, 8'h01);
        wait_writes(w0 + 4, 200, 1'b1, "t2", cyc);
        check("t2_viol", viol, 0);
        check("t2_reads", rd_cnt - r0, 4);
        check("t2_m0", mem[16'h2100], 8'hA1);
        check("t2_m1", mem[16'h2101], 8'hB2);
        check("t2_m2", mem[16'h2102], 8'hC3);
        check("t2_m3", mem[16'h2103], 8'hD4);
        rd_reg(3'd7, rv); check("t2_status", rv, 8'h02);

        // 3: LEN=0 completes immediately with no bus traffic
        wr_reg(3'd7, 8'h00);
        rd_reg(3'd7, rv); check("t3_cleared", rv, 8'h00);
        wr_reg(3'd4, 8'h00); wr_reg(3'd5, 8'h00);
        r0 = rd_cnt; w0 = wr_cnt;
        wr_reg(3'd6, 8'h01);
        rd_reg(3'd7, rv); check("t3_done", rv, 8'h02);
        check("t3_strobes", (rd_cnt - r0) + (wr_cnt - w0), 0);

        // 4: source address wraps
        poke(16'hFFFF, 8'h5A); poke(16'h0000, 8'hC3);
        setup(16'hFFFF, 16'h2200, 16'd2);
        r0 = rd_cnt; w0 = wr_cnt;
        wr_reg(3'd6, 8'h01);
        wait_writes(w0 + 2, 100, 1'b0, "t4", cyc);
        check("t4_rd0_addr", rd_log[r0 % 16], 16'hFFFF);
        check("t4_rd1_addr", rd_log[(r0 + 1) % 16], 16'h0000);
        check("t4_m0", mem[16'h2200], 8'h5A);
        check("t4_m1", mem[16'h2201], 8'hC3);
        rd_reg(3'd0, rv); check("t4_src_lo", rv, 8'h01);
        rd_reg(3'd1, rv); check("t4_src_hi", rv, 8'h00);

        // 5: abort after 2 of 8 bytes; SRC write while busy is ignored
        poke(16'h0300, 8'h10); poke(16'h0301, 8'h20);
        setup(16'h0300, 16'h2300, 16'd8);
        w0 = wr_cnt;
        wr_reg(3'd6, 8'h01);
        wait_writes(w0 + 1, 100, 1'b0, "t5a", cyc);
        wr_reg(3'd0, 8'h77);
        wait_writes(w0 + 2, 100, 1'b0, "t5b", cyc);
        wr_reg(3'd6, 8'h80);
        r0 = rd_cnt; w0 = wr_cnt;
        repeat (10) @(negedge clk);
        check("t5_no_strobes", (rd_cnt - r0) + (wr_cnt - w0), 0);
        rd_reg(3'd7, rv); check("t5_status", rv, 8'h00);
        rd_reg(3'd4, rv); check("t5_len_lo", rv, 8'h06);
        rd_reg(3'd0, rv); check("t5_src_lo", rv, 8'h02);
        rd_reg(3'd1, rv); check("t5_src_hi", rv, 8'h03);
        check("t5_m1", mem[16'h2301], 8'h20);

        // Reset in the middle of a transfer
        setup(16'h0400, 16'h2500, 16'd5);
        w0 = wr_cnt;
        wr_reg(3'd6, 8'h01);
        wait_writes(w0 + 1, 100, 1'b0, "trst", cyc);
        rst = 1'b1;
        #1;
        check("trst_strobes", {dma_grant, bus_r_en, bus_w_en}, 3'b000);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        r0 = rd_cnt; w0 = wr_cnt;
        repeat (8) @(negedge clk);
        check("trst_quiet", (rd_cnt - r0) + (wr_cnt - w0), 0);
        rd_reg(3'd7, rv); check("trst_status", rv, 8'h00);
        rd_reg(3'd4, rv); check("trst_len_lo", rv, 8'h00);
        rd_reg(3'd2, rv); check("trst_dst_lo", rv, 8'h00);

`ifdef DMA_FILL_EN
        // 6: fill mode writes SRC_LO, one byte per cycle, no reads
        setup(16'h00A5, 16'h2400, 16'd3);
        r0 = rd_cnt; w0 = wr_cnt;
        wr_reg(3'd6, 8'h03);
        wait_writes(w0 + 3, 100, 1'b0, "t6", cyc);
        check("t6_cycles", cyc, 3);
        check("t6_reads", rd_cnt - r0, 0);
        check("t6_m0", mem[16'h2400], 8'hA5);
        check("t6_m1", mem[16'h2401], 8'hA5);
        check("t6_m2", mem[16'h2402], 8'hA5);
        rd_reg(3'd0, rv); check("t6_src_lo", rv, 8'hA5);
        rd_reg(3'd6, rv); check("t6_ctrl", rv, 8'h02);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
